muldiv_ctrl: RTL
================

# muldiv_ctrl

Iterative multiply/divide sequencer owning the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI and MFLO. Sits beside the execute-stage ALU and is driven from decode. Runs a 32-iteration shift-add or restoring-divide datapath, then a sign-fixup cycle. Stalls decode while a result is pending.

## Interface
Parameters:
- none; width fixed at 32.

Ports:
- clk  in  1  core clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; upstream asserts it only when the instruction advances.
- op  in  3  `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO`; sampled with start.
- op_a  in  32  forwarded rs value (multiplicand, dividend, or MT source).
- op_b  in  32  forwarded rt value (multiplier, divisor).
- mf_req  in  1  MFHI/MFLO currently in decode.
- mf_sel  in  1  1 = HI, 0 = LO.
- busy  out  1  registered; iteration or fixup in progress.
- stall  out  1  combinational: busy & (start | mf_req).
- mf_data  out  32  combinational: mf_sel ? hi : lo.
- hi  out  32  registered HI.
- lo  out  32  registered LO.
- done  out  1  registered; one-cycle pulse in the first cycle new HI/LO are visible.

## Operation
- States:
  - IDLE: waits for an accepted start.
  - ITER: 32 cycles; a 5-bit counter runs 0..31.
  - FIX: one cycle.
- Acceptance: start is accepted only in IDLE. When start is asserted while busy, stall = 1 and the request is ignored. Upstream holds it until busy drops.
- MTHI/MTLO: on acceptance, hi (or lo) ← op_a at the end of that cycle. State stays IDLE, busy stays 0, no done pulse.
- MULT/MULTU/DIV/DIVU on acceptance:
  - Latch |op_a| and |op_b|; absolute values are taken for signed ops only.
  - Latch the op type, the result signs, and a divide-by-zero flag (op_b == 0).
  - Go to ITER.
- ITER, multiply: add-shift on a 64-bit product register, one multiplier bit per cycle.
- ITER, divide: restoring step on a 64-bit {remainder, quotient} register, one quotient bit per cycle.
- FIX: apply signs, then write {hi, lo} and return to IDLE.
  - Signed multiply: negate the 64-bit product if sign(op_a) ≠ sign(op_b).
  - Signed divide, quotient: negate if the signs differ.
  - Signed divide, remainder: takes the sign of the dividend.
  - Arithmetic is modulo 2^32, so 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
  - Divide by zero, signed or unsigned: lo = 0xFFFFFFFF, hi = original op_a.
- MFHI/MFLO: while idle, mf_data reflects the current registers in the same cycle with no stall.
- Reset mid-operation: the operation is discarded and done never pulses.

## Timing
- Reset values: state IDLE, busy 0, done 0, hi 0, lo 0, counter 0, datapath registers 0.
- Start accepted in cycle 0:
  - busy = 1 in cycles 1–33 (ITER 1–32, FIX 33).
  - hi/lo update at the end of cycle 33.
  - In cycle 34: busy = 0, done = 1, new values on hi, lo and mf_data.
- Latency from start to readable result: 34 cycles.
- An mf_req in cycles 1–33 stalls; in cycle 34 it is served with no stall.
- A new start in cycle 34 is accepted (back-to-back operations).
- start and mf_req are never asserted together. If they are, start takes priority and mf_data still shows the pre-operation value.
- stall has no registered path; it depends only on busy and the same-cycle requests.

## Structure
- Shared constants go in mips_defines.v: `MD_*` op encodings, plus `MFHI`, `MFLO`, `MTHI`, `MTLO`, `MULT`, `MULTU`, `DIV`, `DIVU` funct codes.
- Sub-module muldiv_iter holds the 64-bit working register, the counter-free single-step add-shift/restoring-step logic, and the sign fixup.
- muldiv_ctrl holds the FSM, counter, op/sign latches, the HI/LO registers, and stall/done generation.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → in cycle 34: hi = 0xFFFFFFFE, lo = 0x00000001, done = 1 for exactly one cycle.
- MULT −3 × 5 → hi = 0xFFFFFFFF, lo = 0xFFFFFFF1. DIV −7 / 2 → lo = 0xFFFFFFFD, hi = 0xFFFFFFFF.
- DIVU 7 / 0 → lo = 0xFFFFFFFF, hi = 7. DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
- DIVU 100 / 7 started in cycle 0, mf_req (mf_sel = 0) held from cycle 5:
  - stall = 1 in cycles 5–33.
  - stall = 0 and mf_data = 14 in cycle 34.
  - A second start in cycle 10 is ignored.
- MTHI 0x12345678 while idle → hi = 0x12345678 next cycle, busy stays 0. Then MULT started and rst asserted in cycle 20 → cycle 21: busy = 0, hi = lo = 0, and done stays 0 for 40 cycles.

Source files
------------

// File: rtl/muldiv_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes seen on the
// op port, MIPS funct codes for decode, FSM state type and a sign helper.
package muldiv_ctrl_pkg;

  // Sequencer op encodings driven from decode alongside start.
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // SPECIAL-opcode funct fields that decode maps onto the ops above.
  localparam logic [5:0] MFHI  = 6'h10;
  localparam logic [5:0] MTHI  = 6'h11;
  localparam logic [5:0] MFLO  = 6'h12;
  localparam logic [5:0] MTLO  = 6'h13;
  localparam logic [5:0] MULT  = 6'h18;
  localparam logic [5:0] MULTU = 6'h19;
  localparam logic [5:0] DIV   = 6'h1A;
  localparam logic [5:0] DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2
  } md_state_e;

  // Magnitude of a value that is two's complement only when sgn is set.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative datapath: 64-bit working register stepping one bit per cycle
// (shift-add multiply or restoring divide) plus combinational sign fixup.
module muldiv_iter
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,     // latch magnitudes, clear upper half
  input  logic        step_i,     // advance one iteration
  input  logic        is_div_i,   // latched op type
  input  logic [31:0] a_i,        // |op_a| at load
  input  logic [31:0] b_i,        // |op_b| at load
  input  logic        neg_i,      // negate product / quotient
  input  logic        neg_rem_i,  // negate remainder
  input  logic        dbz_i,      // divisor was zero
  input  logic [31:0] a_orig_i,   // original dividend for divide-by-zero
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] b_q;
  logic [32:0] add_sum;
  logic [32:0] trial;
  logic        ge;
  logic [63:0] prod;
  logic [31:0] quo, rem;

  // One multiply or divide step; divisor magnitude is at most 2^32-1 so the
  // shifted remainder needs 33 bits before the trial subtract.
  always_comb begin
    add_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    trial   = acc_q[63:31] - {1'b0, b_q};
    ge      = (acc_q[63:31] >= {1'b0, b_q});
    if (is_div_i)
      acc_d = ge ? {trial[31:0], acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};
    else
      acc_d = {add_sum, acc_q[31:1]};
  end

  // Working register: loaded on accept, stepped while iterating.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      b_q   <= '0;
    end else if (load_i) begin
      acc_q <= {32'd0, a_i};
      b_q   <= b_i;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  // Sign fixup; modulo-2^32 negation makes 0x80000000 / -1 wrap naturally.
  always_comb begin
    prod = neg_i ? (~acc_q + 64'd1) : acc_q;
    quo  = neg_i ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    rem  = neg_rem_i ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
    if (!is_div_i) begin
      hi_o = prod[63:32];
      lo_o = prod[31:0];
    end else if (dbz_i) begin
      hi_o = a_orig_i;
      lo_o = 32'hFFFF_FFFF;
    end else begin
      hi_o = rem;
      lo_o = quo;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO owner and multiply/divide sequencer: IDLE -> ITER x32 -> FIX.
// Decode is stalled while an operation is in flight.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        mf_req,
  input  logic        mf_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] mf_data,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        done
);

  md_state_e   state_q;
  logic [4:0]  cnt_q;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q, a_orig_q;
  logic        div_q, neg_q, neg_rem_q, dbz_q;
  logic        accept, md_go, sgn, is_div;
  logic [31:0] res_hi, res_lo;

  // Request decode; only an idle sequencer takes a new op.
  always_comb begin
    accept = start && (state_q == ST_IDLE);
    sgn    = (op == MD_MULT) || (op == MD_DIV);
    is_div = (op == MD_DIV)  || (op == MD_DIVU);
    md_go  = accept && (sgn || is_div || (op == MD_MULTU));
  end

  muldiv_iter u_iter (
    .clk       (clk),
    .rst       (rst),
    .load_i    (md_go),
    .step_i    (state_q == ST_ITER),
    .is_div_i  (div_q),
    .a_i       (abs32(op_a, sgn)),
    .b_i       (abs32(op_b, sgn)),
    .neg_i     (neg_q),
    .neg_rem_i (neg_rem_q),
    .dbz_i     (dbz_q),
    .a_orig_i  (a_orig_q),
    .hi_o      (res_hi),
    .lo_o      (res_lo)
  );

  // FSM, iteration counter, op/sign latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      a_orig_q  <= '0;
      div_q     <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dbz_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept && op == MD_MTHI) hi_q <= op_a;
          if (accept && op == MD_MTLO) lo_q <= op_a;
          if (md_go) begin
            div_q     <= is_div;
            neg_q     <= sgn && (op_a[31] ^ op_b[31]);
            neg_rem_q <= sgn && op_a[31];
            dbz_q     <= (op_b == 32'd0);
            a_orig_q  <= op_a;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_ITER;
          end
        end
        ST_ITER: begin
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= ST_FIX;
        end
        ST_FIX: begin
          hi_q    <= res_hi;
          lo_q    <= res_lo;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Decode-facing outputs; stall is purely same-cycle.
  always_comb begin
    busy    = busy_q;
    done    = done_q;
    hi      = hi_q;
    lo      = lo_q;
    stall   = busy_q && (start || mf_req);
    mf_data = mf_sel ? hi_q : lo_q;
  end

endmodule
